// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle. result = {remainder, quotient}, and it only changes
// when a divide completes. stall freezes the pipeline while a divide is in flight.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; latches operand magnitudes and sign flags
//   BUSY  | WIDTH shift/trial-subtract iterations, counter = 0..WIDTH-1
//   DONE  | result valid, stall low; always returns to IDLE
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               signed_div,
    output logic               stall,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0]    IDLE = 2'd0;
    localparam logic [1:0]    BUSY = 2'd1;
    localparam logic [1:0]    DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] rem_q;      // partial remainder
    logic [WIDTH-1:0] dq_q;       // dividend bits shift out of the top, quotient bits in at the bottom
    logic [WIDTH-1:0] dvs_q;      // divisor magnitude
    logic             sign_a;
    logic             sign_b;
    logic             sdiv_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             neg_quot;
    logic             neg_rem;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign mag_b = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // Shifted remainder is WIDTH+1 bits wide; when no borrow the difference always fits in WIDTH bits.
    assign shifted   = {rem_q, dq_q[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, dvs_q});
    assign rem_next  = no_borrow ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    assign quo_next  = {dq_q[WIDTH-2:0], no_borrow};

    // Sign fix-up: quotient follows sign XOR, remainder follows the dividend.
    // The most negative value divided by -1 wraps back to itself, so there is no trap.
    assign neg_quot = sdiv_q && (sign_a ^ sign_b);
    assign neg_rem  = sdiv_q && sign_a;
    assign quo_fix  = neg_quot ? -quo_next : quo_next;
    assign rem_fix  = neg_rem  ? -rem_next : rem_next;

    assign stall = !flush && (((state == IDLE) && start) || (state == BUSY));

    // Control FSM and datapath registers; reset wins over flush, flush wins over start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            counter <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            sdiv_q  <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (opdata2 != '0) begin
                            dq_q    <= mag_a;
                            dvs_q   <= mag_b;
                            rem_q   <= '0;
                            sign_a  <= opdata1[WIDTH-1];
                            sign_b  <= opdata2[WIDTH-1];
                            sdiv_q  <= signed_div;
                            counter <= '0;
                            state   <= BUSY;
                        end else begin
                            result <= {opdata1, {WIDTH{1'b1}}};
                            state  <= DONE;
                        end
                    end
                end
                BUSY: begin
                    rem_q   <= rem_next;
                    dq_q    <= quo_next;
                    counter <= counter + CW'(1);
                    if (counter == LAST) begin
                        result <= {rem_fix, quo_fix};
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Bench for div_radix2: directed cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_radix2;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           start;
    logic           signed_div;
    logic           stall;
    logic [2*W-1:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] last_res;
    bit prev_drop;

    div_radix2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .signed_div (signed_div),
        .stall      (stall),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sd);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sd) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one divide. chained: entered during the previous op's DONE cycle with start still high.
    // drop: release start when the result appears. drop_mid: release start during BUSY.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sd,
                          input bit chained, input bit drop, input bit drop_mid);
        int n;
        logic [63:0] exp;
        exp = model(a, b, sd);
        if (!chained) begin @(negedge clk); #1; end
        opdata1 = a; opdata2 = b; signed_div = sd; start = 1'b1;
        #1;
        if (chained) begin
            check("gap_low", stall, 1'b0);
            @(negedge clk); #1;
        end
        check("stall_c0", stall, 1'b1);
        n = 1;
        @(negedge clk); #1;
        while (stall && n < 100) begin
            opdata1 = $urandom; opdata2 = $urandom;
            if (drop_mid && n == 5) start = 1'b0;
            n++;
            @(negedge clk); #1;
        end
        check("latency", n, (b == 32'd0) ? 1 : W + 1);
        check("result", result, exp);
        last_res = exp;
        if (drop) start = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit rsd, rdrop;
        rst = 1'b0; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_result", result, 64'd0);
        rst = 1'b1;

        run_op(32'd7, 32'd2, 1'b0, 0, 1, 0);
        check("divu_7_2", result, 64'h00000001_00000003);
        run_op(32'hFFFF_FFF9, 32'h2, 1'b1, 0, 1, 0);
        check("div_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1, 0);
        check("div_ovf", result, 64'h00000000_80000000);
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 0, 1, 0);
        check("divu_big", result, 64'h0000000F_0FFFFFFF);
        run_op(32'd5, 32'd0, 1'b0, 0, 1, 0);
        check("div_zero", result, 64'h00000005_FFFFFFFF);
        run_op(32'd1000, 32'd3, 1'b0, 0, 1, 1);

        // Flush at BUSY cycle 10 with start still high.
        @(negedge clk); #1;
        opdata1 = 32'd1234; opdata2 = 32'd5; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall", stall, 1'b0);
        @(negedge clk); #1;
        flush = 1'b0; start = 1'b0;
        #1;
        check("flush_idle", stall, 1'b0);
        check("flush_res", result, last_res);
        repeat (40) @(negedge clk);
        check("flush_hold", result, last_res);
        run_op(32'd9, 32'd3, 1'b0, 0, 1, 0);
        check("divu_9_3", result, 64'h00000000_00000003);

        // Reset at BUSY cycle 20.
        @(negedge clk); #1;
        opdata1 = 32'd999; opdata2 = 32'd4; signed_div = 1'b0; start = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_res", result, 64'd0);
        rst = 1'b1;

        // Back-to-back signed divides with start held through DONE.
        run_op(32'd100, 32'd7, 1'b1, 0, 0, 0);
        check("b2b_1", result, 64'h00000002_0000000E);
        run_op(-32'sd100, 32'd7, 1'b1, 1, 1, 0);
        check("b2b_2", result, 64'hFFFFFFFE_FFFFFFF2);

        prev_drop = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                3:       begin rb = $urandom; ra = 32'h8000_0000; end
                default: rb = $urandom;
            endcase
            rsd   = 1'($urandom_range(0, 1));
            rdrop = (i == 39) ? 1'b1 : 1'($urandom_range(0, 1));
            run_op(ra, rb, rsd, !prev_drop, rdrop, 0);
            prev_drop = rdrop;
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
